// File: rtl/sprite_renderer_pkg.sv
// Shared constants and types for the sprite renderer.
// Sprite ROM geometry: 32x32 pixels per frame, up to 4 frames, 12-bit
// address laid out as {frame_sel[1:0], row[4:0], col[4:0]}, 12-bit colour.
package sprite_renderer_pkg;

    localparam int SPRITE_DIM    = 32;
    localparam int SPRITE_IDX_W  = 5;
    localparam int ROM_ADDR_W    = 12;
    localparam int FRAME_SEL_W   = 2;
    localparam int COLOR_W       = 12;

    localparam logic [COLOR_W-1:0] DEFAULT_TRANSPARENT_KEY = 12'hF0F;

    typedef logic [SPRITE_IDX_W-1:0] sprite_idx_t;
    typedef logic [FRAME_SEL_W-1:0]  frame_sel_t;

    // Horizontal mirror of a sprite column index.
    function automatic sprite_idx_t mirror_idx(input sprite_idx_t idx, input logic flip);
        return flip ? (sprite_idx_t'(SPRITE_DIM - 1) - idx) : idx;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation frame sequencer for the sprite renderer.
// Counts video frames (frame_tick) and advances frame_sel every
// FRAMES_PER_STEP frames, wrapping after NUM_FRAMES. Disabling anim_en
// snaps back to frame 0 on the next frame_tick.
// Ports:
//   clk        in   pixel clock
//   reset      in   asynchronous, active-high
//   frame_tick in   one-cycle pulse per video frame
//   anim_en    in   advance animation when high
//   frame_sel  out  current animation frame (ROM addr[11:10])
module sprite_anim_ctrl
    import sprite_renderer_pkg::*;
#(
    parameter int NUM_FRAMES      = 4,
    parameter int FRAMES_PER_STEP = 8
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       anim_en,
    output frame_sel_t frame_sel
);

    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
    localparam frame_sel_t        FRAME_LAST = FRAME_SEL_W'(NUM_FRAMES - 1);

    logic [STEP_W-1:0] r_step;
    frame_sel_t        r_frame_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step      <= '0;
            r_frame_sel <= '0;
        end else if (frame_tick) begin
            if (!anim_en) begin
                r_step      <= '0;
                r_frame_sel <= '0;
            end else if (r_step == STEP_LAST) begin
                r_step <= '0;
                // With NUM_FRAMES=1 FRAME_LAST is 0, so this holds frame 0.
                r_frame_sel <= (r_frame_sel == FRAME_LAST) ? '0 : r_frame_sel + 1'b1;
            end else begin
                r_step <= r_step + 1'b1;
            end
        end
    end

    assign frame_sel = r_frame_sel;

endmodule

// File: rtl/sprite_renderer.sv
// Sprite pixel-address generator and colour stage.
// Maps the VGA beam position onto a 32x32 (optionally integer-scaled)
// sprite, drives the sprite ROM address, and turns the returned ROM word
// into rgb_out/sprite_hit with colour-key transparency. Total latency from
// hc/vc to rgb_out/sprite_hit is 3 clocks.
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   hc, vc, bright      beam position and visible-area flag
//   frame_tick          once-per-frame pulse; latches sprite_x/y/flip
//   sprite_x, sprite_y  sprite top-left in screen pixels
//   flip, anim_en       horizontal mirror, animation enable
//   rom_addr            sprite ROM address (ROM read is 1-cycle registered)
//   pixel_data          ROM read data
//   rgb_out, sprite_hit sprite colour (0 when no hit) and opaque-hit flag
module sprite_renderer
    import sprite_renderer_pkg::*;
#(
    parameter int                 COORD_W         = 10,
    parameter int                 SCALE_LOG2      = 0,
    parameter int                 NUM_FRAMES      = 4,
    parameter int                 FRAMES_PER_STEP = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = DEFAULT_TRANSPARENT_KEY
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_W-1:0]    hc,
    input  logic [COORD_W-1:0]    vc,
    input  logic                  bright,
    input  logic                  frame_tick,
    input  logic [COORD_W-1:0]    sprite_x,
    input  logic [COORD_W-1:0]    sprite_y,
    input  logic                  flip,
    input  logic                  anim_en,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [COLOR_W-1:0]    pixel_data,
    output logic [COLOR_W-1:0]    rgb_out,
    output logic                  sprite_hit
);

    localparam int BOX_PX = SPRITE_DIM << SCALE_LOG2;

    logic [COORD_W-1:0]    r_x_lat;
    logic [COORD_W-1:0]    r_y_lat;
    logic                  r_flip;
    logic                  r_armed;
    logic [ROM_ADDR_W-1:0] r_rom_addr;
    logic                  r_hit_d1;
    logic                  r_hit_d2;
    logic [COLOR_W-1:0]    r_rgb;
    logic                  r_sprite_hit;

    frame_sel_t            w_frame_sel;
    logic [COORD_W:0]      w_dx;
    logic [COORD_W:0]      w_dy;
    logic                  w_in_box;
    sprite_idx_t           w_col;
    sprite_idx_t           w_row;
    logic                  w_opaque;

    sprite_anim_ctrl #(
        .NUM_FRAMES      (NUM_FRAMES),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_anim (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .anim_en    (anim_en),
        .frame_sel  (w_frame_sel)
    );

    // Position/flip only change at frame_tick so a sprite never tears mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_lat <= '0;
            r_y_lat <= '0;
            r_flip  <= 1'b0;
            r_armed <= 1'b0;
        end else if (frame_tick) begin
            r_x_lat <= sprite_x;
            r_y_lat <= sprite_y;
            r_flip  <= flip;
            r_armed <= 1'b1;
        end
    end

    // One extra bit so a beam left of / above the sprite goes negative.
    assign w_dx = {1'b0, hc} - {1'b0, r_x_lat};
    assign w_dy = {1'b0, vc} - {1'b0, r_y_lat};

    assign w_in_box = !w_dx[COORD_W] && !w_dy[COORD_W]
                   && (w_dx[COORD_W-1:0] < COORD_W'(BOX_PX))
                   && (w_dy[COORD_W-1:0] < COORD_W'(BOX_PX));

    assign w_col = mirror_idx(SPRITE_IDX_W'(w_dx[COORD_W-1:0] >> SCALE_LOG2), r_flip);
    assign w_row = SPRITE_IDX_W'(w_dy[COORD_W-1:0] >> SCALE_LOG2);

    // Stage 1: address compute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_hit_d1   <= 1'b0;
        end else begin
            if (w_in_box) begin
                r_rom_addr <= {w_frame_sel, w_row, w_col};
            end
            r_hit_d1 <= w_in_box & bright & r_armed;
        end
    end

    // Stage 2: aligns hit with the ROM's registered read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_d2 <= 1'b0;
        end else begin
            r_hit_d2 <= r_hit_d1;
        end
    end

    assign w_opaque = r_hit_d2 && (pixel_data != TRANSPARENT_KEY);

    // Stage 3: colour key and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sprite_hit <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_sprite_hit <= w_opaque;
            r_rgb        <= w_opaque ? pixel_data : '0;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign rgb_out    = r_rgb;
    assign sprite_hit = r_sprite_hit;

endmodule

// File: tb/tb_sprite_renderer.sv
module tb_sprite_renderer;

    logic        clk;
    logic        reset;
    logic [9:0]  hc, vc, sprite_x, sprite_y;
    logic        bright, frame_tick, flip, anim_en;
    logic [11:0] rom_addr, pixel_data, rgb_out;
    logic        sprite_hit;
    logic [11:0] rom_addr_s, pixel_data_s, rgb_out_s;
    logic        sprite_hit_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        ca;
        logic [11:0] a;
        logic        hit;
    } vec_t;

    sprite_renderer dut (
        .clk(clk), .reset(reset), .hc(hc), .vc(vc), .bright(bright),
        .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .flip(flip), .anim_en(anim_en), .rom_addr(rom_addr),
        .pixel_data(pixel_data), .rgb_out(rgb_out), .sprite_hit(sprite_hit)
    );

    sprite_renderer #(.SCALE_LOG2(1)) dut_s (
        .clk(clk), .reset(reset), .hc(hc), .vc(vc), .bright(bright),
        .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .flip(flip), .anim_en(anim_en), .rom_addr(rom_addr_s),
        .pixel_data(pixel_data_s), .rgb_out(rgb_out_s), .sprite_hit(sprite_hit_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM contents: (0,0) of frame 0 is green, (row3,col4) is the key.
    function automatic logic [11:0] rom_word(input logic [11:0] a);
        logic [11:0] w;
        if (a == 12'h000) return 12'h0F0;
        if (a == 12'h064) return 12'hF0F;
        w = a ^ 12'h5A5;
        if (w == 12'hF0F) w = 12'h123;
        return w;
    endfunction

    always @(posedge clk) begin
        pixel_data   <= rom_word(rom_addr);
        pixel_data_s <= rom_word(rom_addr_s);
    end

    task automatic tick();
        frame_tick = 1'b1;
        bright     = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Present one pixel, capture rom_addr at +1 and rgb/hit at +3.
    task automatic probe(input logic [9:0] h, input logic [9:0] v,
                         output logic [11:0] a, output logic [11:0] rgb, output logic hit,
                         output logic [11:0] a_s, output logic [11:0] rgb_s, output logic hit_s);
        hc = h; vc = v; bright = 1'b1;
        @(negedge clk);
        a   = rom_addr;
        a_s = rom_addr_s;
        hc = 10'd1023; vc = 10'd0; bright = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rgb = rgb_out;   hit = sprite_hit;
        rgb_s = rgb_out_s; hit_s = sprite_hit_s;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rom_addr, rom_addr_s} !== 24'h0) begin
            n_fail++; $display("FAIL reset_addr got=%h/%h exp=000", rom_addr, rom_addr_s);
        end
        n_checks++;
        if ({rgb_out, rgb_out_s} !== 24'h0) begin
            n_fail++; $display("FAIL reset_rgb got=%h/%h exp=000", rgb_out, rgb_out_s);
        end
        n_checks++;
        if ({sprite_hit, sprite_hit_s} !== 2'b00) begin
            n_fail++; $display("FAIL reset_hit got=%b/%b exp=0", sprite_hit, sprite_hit_s);
        end
    endtask

    task automatic test_unarmed();
        int bad = 0;
        for (int v = 0; v < 40; v++) begin
            for (int h = 0; h < 70; h++) begin
                hc = 10'(h); vc = 10'(v); bright = 1'b1;
                @(negedge clk);
                if (sprite_hit || sprite_hit_s || rgb_out != 0 || rgb_out_s != 0) bad++;
            end
        end
        bright = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sprite_hit || sprite_hit_s || rgb_out != 0 || rgb_out_s != 0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL unarmed_sweep hits got=%0d exp=0", bad);
        end
    endtask

    task automatic test_basic();
        vec_t t [8];
        logic [11:0] a, r, as_, rs; logic h, hs;
        sprite_x = 10'd100; sprite_y = 10'd50; flip = 1'b0; anim_en = 1'b0;
        tick();
        t = '{ '{10'd100, 10'd50, 1'b1, 12'h000, 1'b1},
               '{10'd101, 10'd50, 1'b1, 12'h001, 1'b1},
               '{10'd131, 10'd81, 1'b1, 12'h3FF, 1'b1},
               '{10'd115, 10'd60, 1'b1, 12'h14F, 1'b1},
               '{10'd99,  10'd50, 1'b0, 12'h000, 1'b0},
               '{10'd100, 10'd49, 1'b0, 12'h000, 1'b0},
               '{10'd132, 10'd50, 1'b0, 12'h000, 1'b0},
               '{10'd100, 10'd82, 1'b0, 12'h000, 1'b0} };
        foreach (t[i]) begin
            probe(t[i].h, t[i].v, a, r, h, as_, rs, hs);
            if (t[i].ca) begin
                n_checks++;
                if (a !== t[i].a) begin
                    n_fail++; $display("FAIL basic[%0d] rom_addr got=%h exp=%h", i, a, t[i].a);
                end
            end
            n_checks++;
            if (h !== t[i].hit || r !== (t[i].hit ? rom_word(t[i].a) : 12'h000)) begin
                n_fail++; $display("FAIL basic[%0d] hit/rgb got=%b/%h exp=%b/%h", i, h, r,
                                   t[i].hit, t[i].hit ? rom_word(t[i].a) : 12'h000);
            end
        end
    endtask

    task automatic test_transparent();
        vec_t t [5];
        logic [11:0] a, r, as_, rs; logic h, hs;
        t = '{ '{10'd104, 10'd53, 1'b1, 12'h064, 1'b0},
               '{10'd103, 10'd53, 1'b1, 12'h063, 1'b1},
               '{10'd105, 10'd53, 1'b1, 12'h065, 1'b1},
               '{10'd104, 10'd52, 1'b1, 12'h044, 1'b1},
               '{10'd104, 10'd54, 1'b1, 12'h084, 1'b1} };
        foreach (t[i]) begin
            probe(t[i].h, t[i].v, a, r, h, as_, rs, hs);
            n_checks++;
            if (a !== t[i].a) begin
                n_fail++; $display("FAIL transp[%0d] rom_addr got=%h exp=%h", i, a, t[i].a);
            end
            n_checks++;
            if (h !== t[i].hit || r !== (t[i].hit ? rom_word(t[i].a) : 12'h000)) begin
                n_fail++; $display("FAIL transp[%0d] hit/rgb got=%b/%h exp=%b/%h", i, h, r,
                                   t[i].hit, t[i].hit ? rom_word(t[i].a) : 12'h000);
            end
        end
    endtask

    task automatic test_flip();
        vec_t t [4];
        logic [11:0] a, r, as_, rs; logic h, hs;
        flip = 1'b1;
        tick();
        t = '{ '{10'd100, 10'd50, 1'b1, 12'h01F, 1'b1},
               '{10'd131, 10'd50, 1'b1, 12'h000, 1'b1},
               '{10'd104, 10'd53, 1'b1, 12'h07B, 1'b1},
               '{10'd132, 10'd50, 1'b0, 12'h000, 1'b0} };
        foreach (t[i]) begin
            probe(t[i].h, t[i].v, a, r, h, as_, rs, hs);
            if (t[i].ca) begin
                n_checks++;
                if (a !== t[i].a) begin
                    n_fail++; $display("FAIL flip[%0d] rom_addr got=%h exp=%h", i, a, t[i].a);
                end
            end
            n_checks++;
            if (h !== t[i].hit || r !== (t[i].hit ? rom_word(t[i].a) : 12'h000)) begin
                n_fail++; $display("FAIL flip[%0d] hit/rgb got=%b/%h exp=%b/%h", i, h, r,
                                   t[i].hit, t[i].hit ? rom_word(t[i].a) : 12'h000);
            end
        end
    endtask

    task automatic test_latch();
        logic [11:0] a, r, as_, rs; logic h, hs;
        sprite_x = 10'd200;
        probe(10'd100, 10'd50, a, r, h, as_, rs, hs);
        n_checks++;
        if (a !== 12'h01F || h !== 1'b1) begin
            n_fail++; $display("FAIL latch_old_pos addr/hit got=%h/%b exp=01f/1", a, h);
        end
        probe(10'd200, 10'd50, a, r, h, as_, rs, hs);
        n_checks++;
        if (h !== 1'b0) begin
            n_fail++; $display("FAIL latch_new_pos_early hit got=%b exp=0", h);
        end
        tick();
        probe(10'd200, 10'd50, a, r, h, as_, rs, hs);
        n_checks++;
        if (a !== 12'h01F || h !== 1'b1 || r !== rom_word(12'h01F)) begin
            n_fail++; $display("FAIL latch_after_tick addr/hit/rgb got=%h/%b/%h exp=01f/1/%h",
                               a, h, r, rom_word(12'h01F));
        end
    endtask

    task automatic test_tick_same_cycle();
        logic [11:0] a, r, as_, rs; logic h, hs;
        sprite_x = 10'd300; flip = 1'b0;
        hc = 10'd200; vc = 10'd50; bright = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        a = rom_addr;
        hc = 10'd1023; vc = 10'd0; bright = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (a !== 12'h01F || sprite_hit !== 1'b1 || rgb_out !== rom_word(12'h01F)) begin
            n_fail++; $display("FAIL tick_same_cycle addr/hit/rgb got=%h/%b/%h exp=01f/1/%h",
                               a, sprite_hit, rgb_out, rom_word(12'h01F));
        end
        probe(10'd200, 10'd50, a, r, h, as_, rs, hs);
        n_checks++;
        if (h !== 1'b0) begin
            n_fail++; $display("FAIL tick_same_cycle_old_pos hit got=%b exp=0", h);
        end
        probe(10'd300, 10'd50, a, r, h, as_, rs, hs);
        n_checks++;
        if (a !== 12'h000 || h !== 1'b1 || r !== 12'h0F0) begin
            n_fail++; $display("FAIL tick_same_cycle_new_pos addr/hit/rgb got=%h/%b/%h exp=000/1/0f0",
                               a, h, r);
        end
    endtask

    task automatic test_scale();
        vec_t t [7];
        logic [11:0] a, r, as_, rs; logic h, hs;
        sprite_x = 10'd0; sprite_y = 10'd0; flip = 1'b0;
        tick();
        t = '{ '{10'd0,  10'd0,  1'b1, 12'h000, 1'b1},
               '{10'd1,  10'd0,  1'b1, 12'h000, 1'b1},
               '{10'd2,  10'd0,  1'b1, 12'h001, 1'b1},
               '{10'd63, 10'd0,  1'b1, 12'h01F, 1'b1},
               '{10'd0,  10'd63, 1'b1, 12'h3E0, 1'b1},
               '{10'd3,  10'd5,  1'b1, 12'h041, 1'b1},
               '{10'd64, 10'd0,  1'b0, 12'h000, 1'b0} };
        foreach (t[i]) begin
            probe(t[i].h, t[i].v, a, r, h, as_, rs, hs);
            if (t[i].ca) begin
                n_checks++;
                if (as_ !== t[i].a) begin
                    n_fail++; $display("FAIL scale[%0d] rom_addr got=%h exp=%h", i, as_, t[i].a);
                end
            end
            n_checks++;
            if (hs !== t[i].hit || rs !== (t[i].hit ? rom_word(t[i].a) : 12'h000)) begin
                n_fail++; $display("FAIL scale[%0d] hit/rgb got=%b/%h exp=%b/%h", i, hs, rs,
                                   t[i].hit, t[i].hit ? rom_word(t[i].a) : 12'h000);
            end
        end
        // Unscaled instance at the same spot: hc=32 is already outside.
        probe(10'd32, 10'd0, a, r, h, as_, rs, hs);
        n_checks++;
        if (h !== 1'b0 || hs !== 1'b1 || as_ !== 12'h010) begin
            n_fail++; $display("FAIL scale_vs_unscaled hit/hit_s/addr_s got=%b/%b/%h exp=0/1/010",
                               h, hs, as_);
        end
        sprite_x = 10'd10;
        probe(10'd0, 10'd0, a, r, h, as_, rs, hs);
        n_checks++;
        if (hs !== 1'b1 || as_ !== 12'h000) begin
            n_fail++; $display("FAIL scale_midframe_x hit/addr got=%b/%h exp=1/000", hs, as_);
        end
        tick();
        probe(10'd0, 10'd0, a, r, h, as_, rs, hs);
        n_checks++;
        if (hs !== 1'b0) begin
            n_fail++; $display("FAIL scale_after_tick_left hit got=%b exp=0", hs);
        end
        probe(10'd12, 10'd0, a, r, h, as_, rs, hs);
        n_checks++;
        if (hs !== 1'b1 || as_ !== 12'h001) begin
            n_fail++; $display("FAIL scale_after_tick_in hit/addr got=%b/%h exp=1/001", hs, as_);
        end
    endtask

    task automatic test_clip();
        vec_t t [4];
        logic [11:0] a, r, as_, rs; logic h, hs;
        sprite_x = 10'd1000; sprite_y = 10'd1000;
        tick();
        t = '{ '{10'd1023, 10'd1023, 1'b1, 12'h2F7, 1'b1},
               '{10'd1000, 10'd1000, 1'b1, 12'h000, 1'b1},
               '{10'd999,  10'd1023, 1'b0, 12'h000, 1'b0},
               '{10'd1023, 10'd999,  1'b0, 12'h000, 1'b0} };
        foreach (t[i]) begin
            probe(t[i].h, t[i].v, a, r, h, as_, rs, hs);
            if (t[i].ca) begin
                n_checks++;
                if (a !== t[i].a) begin
                    n_fail++; $display("FAIL clip[%0d] rom_addr got=%h exp=%h", i, a, t[i].a);
                end
            end
            n_checks++;
            if (h !== t[i].hit || r !== (t[i].hit ? rom_word(t[i].a) : 12'h000)) begin
                n_fail++; $display("FAIL clip[%0d] hit/rgb got=%b/%h exp=%b/%h", i, h, r,
                                   t[i].hit, t[i].hit ? rom_word(t[i].a) : 12'h000);
            end
        end
    endtask

    task automatic test_anim();
        logic [11:0] a, r, as_, rs, ea; logic h, hs;
        logic [1:0] ef;
        sprite_x = 10'd0; sprite_y = 10'd0; flip = 1'b0; anim_en = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            if (k == 41) anim_en = 1'b0;
            tick();
            if (k == 7 || k == 8 || k == 16 || k == 24 || k == 32 || k == 40 || k == 41) begin
                case (k)
                    8:       ef = 2'd1;
                    16:      ef = 2'd2;
                    24:      ef = 2'd3;
                    40:      ef = 2'd1;
                    default: ef = 2'd0;
                endcase
                ea = {ef, 10'd0};
                probe(10'd0, 10'd0, a, r, h, as_, rs, hs);
                n_checks++;
                if (a !== ea || h !== 1'b1 || r !== rom_word(ea)) begin
                    n_fail++; $display("FAIL anim_tick%0d addr/hit/rgb got=%h/%b/%h exp=%h/1/%h",
                                       k, a, h, r, ea, rom_word(ea));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] a, r, as_, rs; logic h, hs;
        hc = 10'd5; vc = 10'd5; bright = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rom_addr !== 12'h0A5) begin
            n_fail++; $display("FAIL midreset_pre addr got=%h exp=0a5", rom_addr);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (rom_addr !== 12'h000 || sprite_hit !== 1'b0 || rgb_out !== 12'h000) begin
            n_fail++; $display("FAIL midreset_flush addr/hit/rgb got=%h/%b/%h exp=000/0/000",
                               rom_addr, sprite_hit, rgb_out);
        end
        @(negedge clk);
        reset = 1'b0;
        bright = 1'b0;
        probe(10'd5, 10'd5, a, r, h, as_, rs, hs);
        n_checks++;
        if (h !== 1'b0 || r !== 12'h000 || hs !== 1'b0) begin
            n_fail++; $display("FAIL midreset_unarmed hit/rgb got=%b/%h exp=0/000", h, r);
        end
        tick();
        probe(10'd5, 10'd5, a, r, h, as_, rs, hs);
        n_checks++;
        if (a !== 12'h0A5 || h !== 1'b1 || r !== rom_word(12'h0A5)) begin
            n_fail++; $display("FAIL midreset_rearmed addr/hit/rgb got=%h/%b/%h exp=0a5/1/%h",
                               a, h, r, rom_word(12'h0A5));
        end
    endtask

    initial begin
        reset = 1'b1;
        hc = '0; vc = '0; bright = 1'b0; frame_tick = 1'b0;
        sprite_x = '0; sprite_y = '0; flip = 1'b0; anim_en = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_unarmed();
        test_basic();
        test_transparent();
        test_flip();
        test_latch();
        test_tick_same_cycle();
        test_scale();
        test_clip();
        test_anim();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
